// File: rtl/pt_write_port_pkg.sv
// Shared types and constants for the projective-transform pixel write port.
package pt_write_port_pkg;

  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int ADDR_W = 19;
  localparam int PIX_W  = 18;
  localparam int X_W    = 10;
  localparam int Y_W    = 9;

  localparam int ENTRY_W = X_W + Y_W + PIX_W;

  // One buffered pixel write, x in the most significant bits.
  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [PIX_W-1:0] pixel;
  } pt_entry_t;

  typedef enum logic {
    ENG_IDLE  = 1'b0,
    ENG_ISSUE = 1'b1
  } eng_state_e;

  // Linear frame-buffer address y*H_RES + x. The constant multiply folds to
  // (y<<9)+(y<<7) for 640; the largest in-range result (307199) fits ADDR_W.
  function automatic logic [ADDR_W-1:0] pt_lin_addr(input logic [X_W-1:0] x,
                                                    input logic [Y_W-1:0] y);
    logic [ADDR_W-1:0] yw;
    yw = ADDR_W'(y);
    return (yw * ADDR_W'(H_RES)) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/pt_fifo.sv
// Single-clock FIFO holding pending pixel writes. DEPTH must be a power of 2,
// so the pointers wrap naturally. A push while full is legal only when a pop
// happens on the same edge; the caller guarantees this.
module pt_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 37,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  // Storage array: written on push, no reset needed.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/pt_write_port.sv
// Pixel write responder: buffers (x,y,pixel) strobes, converts them to linear
// frame-buffer addresses and issues them one at a time to the memory port.
//
// Memory handshake: mem_we is the valid, mem_ack the ready. A transfer happens
// on an edge where both are 1. While mem_we=1 without mem_ack, mem_addr and
// mem_data stay stable. On a transfer the next entry (if any) is presented
// from the same edge with no idle cycle in between.
module pt_write_port
  import pt_write_port_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pt_wr,
  input  logic [9:0]        pt_x,
  input  logic [8:0]        pt_y,
  input  logic [PIX_W-1:0]  pt_pixel_write,
  output logic              ptflag,
  input  logic              frame_flag,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_data,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic [15:0]       drop_count,
  output logic              dbg_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  eng_state_e        state_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [PIX_W-1:0]  mem_data_q;
  logic              ptflag_q;
  logic              ptflag_d;
  logic [15:0]       drop_count_q;
  logic [15:0]       drop_count_d;

  pt_entry_t         push_entry;
  pt_entry_t         head_entry;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     count_next;
  logic              fifo_full;
  logic              fifo_empty;
  logic              in_range;
  logic              pop;
  logic              accept;
  logic              discard;

  assign push_entry = {pt_x, pt_y, pt_pixel_write};

  // The engine takes the head whenever it is idle or its current write is
  // being acknowledged on this edge.
  assign pop      = !fifo_empty && ((state_q == ENG_IDLE) || mem_ack);
  assign in_range = (pt_x < X_W'(H_RES)) && (pt_y < Y_W'(V_RES));
  assign accept   = pt_wr && in_range && (!fifo_full || pop);
  assign discard  = pt_wr && !accept;

  pt_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Flow control: keep one spare slot for a strobe already in flight from
  // the producer's registered response.
  always_comb begin
    count_next = fifo_count + CW'(accept) - CW'(pop);
    ptflag_d   = (count_next <= CW'(DEPTH - 2));
  end

  // Saturating discard counter; a frame_flag clear wins over a discard.
  always_comb begin
    drop_count_d = drop_count_q;
    if (frame_flag) begin
      drop_count_d = '0;
    end else if (discard && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  // Registered flow-control flag and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptflag_q     <= 1'b1;
      drop_count_q <= '0;
    end else begin
      ptflag_q     <= ptflag_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Write engine: loads the FIFO head into the memory port registers and
  // holds it until acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ENG_IDLE;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      case (state_q)
        ENG_IDLE: begin
          if (!fifo_empty) begin
            mem_addr_q <= pt_lin_addr(head_entry.x, head_entry.y);
            mem_data_q <= head_entry.pixel;
            mem_we_q   <= 1'b1;
            state_q    <= ENG_ISSUE;
          end
        end
        ENG_ISSUE: begin
          if (mem_ack) begin
            if (!fifo_empty) begin
              mem_addr_q <= pt_lin_addr(head_entry.x, head_entry.y);
              mem_data_q <= head_entry.pixel;
            end else begin
              mem_we_q <= 1'b0;
              state_q  <= ENG_IDLE;
            end
          end
        end
        default: begin
          mem_we_q <= 1'b0;
          state_q  <= ENG_IDLE;
        end
      endcase
    end
  end

  assign ptflag     = ptflag_q;
  assign drop_count = drop_count_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign dbg_state  = (state_q == ENG_ISSUE);

endmodule
